// File: rtl/monitor_pkg.sv
// monitor_pkg: shared definitions for the run_monitor block.
//   state_t      - run-control state codes exposed on state_o
//   CAUSE_*      - stop cause codes latched on cause_o
//                  (anomaly causes are 1+i for the lowest set anomaly bit i)
package monitor_pkg;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_RUN   = 3'd1,
    ST_HALT  = 3'd2,
    ST_ERROR = 3'd3,
    ST_STEP  = 3'd4
  } state_t;

  localparam logic [3:0] CAUSE_NONE       = 4'd0;
  localparam logic [3:0] CAUSE_ECALL      = 4'd8;
  localparam logic [3:0] CAUSE_EBREAK     = 4'd9;
  localparam logic [3:0] CAUSE_BREAKPOINT = 4'd10;

endpackage

// File: rtl/run_monitor_bp_match.sv
// bp_match: PC breakpoint comparator array.
//   i_pc      - current PC
//   i_bp_en   - per-breakpoint enable
//   i_bp_addr - packed breakpoint addresses, entry k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_hit     - high when any enabled breakpoint equals i_pc
module bp_match #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_BP     = 2
) (
  input  logic [DATA_WIDTH-1:0]        i_pc,
  input  logic [NUM_BP-1:0]            i_bp_en,
  input  logic [NUM_BP*DATA_WIDTH-1:0] i_bp_addr,
  output logic                         o_hit
);

  logic w_hit;

  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < NUM_BP; k++) begin
      if (i_bp_en[k] && (i_bp_addr[k*DATA_WIDTH +: DATA_WIDTH] == i_pc)) begin
        w_hit = 1'b1;
      end
    end
  end

  assign o_hit = w_hit;

endmodule

// File: rtl/run_monitor.sv
// run_monitor: run-control block between the PC register and the CPU core.
// Watches the exception vector and PC breakpoints, gates the PC advance,
// handles halt/resume/single-step, latches stop cause and PC, and counts
// cycles and retired instructions.
//   clk_i/rst_i         - clock, asynchronous active-high reset
//   pc_i, exc_i         - current PC and its exception flags
//   run_i, step_i       - resume / single-step requests (used in HALT only)
//   bp_en_i, bp_addr_i  - breakpoint enables and packed addresses
//   pc_we_o             - PC advance enable (combinational)
//   state_o             - current state code (monitor_pkg::state_t)
//   cause_o, epc_o      - latched stop cause and stop PC
//   cycles_o, instret_o - free-running cycle and retired-instruction counters
// Handshake note: run_i/step_i are level requests sampled each HALT cycle;
// there is no acknowledge, leaving HALT is the acknowledge.
module run_monitor
  import monitor_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int EXC_WIDTH    = 6,
  parameter int ANOMALY_TOP  = 3,
  parameter int ECALL_BIT    = 4,
  parameter int EBREAK_BIT   = 5,
  parameter int NUM_BP       = 2,
  parameter int CNT_WIDTH    = 32,
  parameter int START_HALTED = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        pc_i,
  input  logic [EXC_WIDTH-1:0]         exc_i,
  input  logic                         run_i,
  input  logic                         step_i,
  input  logic [NUM_BP-1:0]            bp_en_i,
  input  logic [NUM_BP*DATA_WIDTH-1:0] bp_addr_i,
  output logic                         pc_we_o,
  output logic [2:0]                   state_o,
  output logic [3:0]                   cause_o,
  output logic [DATA_WIDTH-1:0]        epc_o,
  output logic [CNT_WIDTH-1:0]         cycles_o,
  output logic [CNT_WIDTH-1:0]         instret_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                r_state;
  logic                  r_skip;
  logic [3:0]            r_cause;
  logic [DATA_WIDTH-1:0] r_epc;
  logic [CNT_WIDTH-1:0]  r_cycles;
  logic [CNT_WIDTH-1:0]  r_instret;

  logic       w_bp_hit;
  logic       w_anomaly;
  logic       w_ecall;
  logic       w_ebreak;
  logic       w_stop;
  logic       w_pc_we;
  logic [3:0] w_cause;

  bp_match #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_BP     (NUM_BP)
  ) u_bp_match (
    .i_pc      (pc_i),
    .i_bp_en   (bp_en_i),
    .i_bp_addr (bp_addr_i),
    .o_hit     (w_bp_hit)
  );

  assign w_anomaly = |exc_i[ANOMALY_TOP:0];
  assign w_ecall   = exc_i[ECALL_BIT];
  assign w_ebreak  = exc_i[EBREAK_BIT];

  // skip lets the first instruction after a resume pass the debug event that
  // halted it; fatal anomalies are never masked.
  assign w_stop  = w_anomaly | (!r_skip & (w_ecall | w_ebreak | w_bp_hit));
  assign w_pc_we = ((r_state == ST_RUN) | (r_state == ST_STEP)) & !w_stop;

  // Cause priority, lowest first so higher priorities overwrite.
  always_comb begin
    w_cause = CAUSE_NONE;
    if (w_bp_hit) w_cause = CAUSE_BREAKPOINT;
    if (w_ebreak) w_cause = CAUSE_EBREAK;
    if (w_ecall)  w_cause = CAUSE_ECALL;
    for (int i = ANOMALY_TOP; i >= 0; i--) begin
      if (exc_i[i]) w_cause = 4'(i + 1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_RST;
      r_skip    <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_epc     <= '0;
      r_cycles  <= '0;
      r_instret <= '0;
    end else begin
      if (r_state != ST_RST) r_cycles <= r_cycles + CNT_ONE;
      if (w_pc_we)           r_instret <= r_instret + CNT_ONE;
      r_skip <= 1'b0;
      case (r_state)
        ST_RST: r_state <= (START_HALTED != 0) ? ST_HALT : ST_RUN;
        ST_RUN, ST_STEP: begin
          if (w_stop) begin
            r_cause <= w_cause;
            r_epc   <= pc_i;
            r_state <= w_anomaly ? ST_ERROR : ST_HALT;
          end else if (r_state == ST_STEP) begin
            r_state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (run_i) begin
            r_state <= ST_RUN;
            r_skip  <= 1'b1;
          end else if (step_i) begin
            r_state <= ST_STEP;
            r_skip  <= 1'b1;
          end
        end
        ST_ERROR: r_state <= ST_ERROR;
        default:  r_state <= ST_RST;
      endcase
    end
  end

  assign pc_we_o   = w_pc_we;
  assign state_o   = r_state;
  assign cause_o   = r_cause;
  assign epc_o     = r_epc;
  assign cycles_o  = r_cycles;
  assign instret_o = r_instret;

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;
  import monitor_pkg::*;

  localparam int DW = 64;
  localparam int NB = 2;
  localparam int CW = 4;

  // clock / reset
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [DW-1:0]    pc_i = 64'h8000_0000;
  logic [5:0]       exc_i = '0;
  logic             run_i = 1'b0;
  logic             step_i = 1'b0;
  logic [NB-1:0]    bp_en_i = '0;
  logic [NB*DW-1:0] bp_addr_i = '0;
  logic             pc_we_o;
  logic [2:0]       state_o;
  logic [3:0]       cause_o;
  logic [DW-1:0]    epc_o;
  logic [CW-1:0]    cycles_o;
  logic [CW-1:0]    instret_o;

  run_monitor #(.CNT_WIDTH(CW)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .pc_i      (pc_i),
    .exc_i     (exc_i),
    .run_i     (run_i),
    .step_i    (step_i),
    .bp_en_i   (bp_en_i),
    .bp_addr_i (bp_addr_i),
    .pc_we_o   (pc_we_o),
    .state_o   (state_o),
    .cause_o   (cause_o),
    .epc_o     (epc_o),
    .cycles_o  (cycles_o),
    .instret_o (instret_o)
  );

  // scoreboard state
  int            n_chk = 0;
  int            n_fail = 0;
  logic [CW-1:0] cyc_exp = '0;
  logic [CW-1:0] ins_exp = '0;
  bit            live = 1'b0;
  logic [3:0]    exp_cause = '0;
  logic [DW-1:0] exp_epc = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input state_t st);
    chk({tag, ":state"},   64'(state_o),   64'(st));
    chk({tag, ":cause"},   64'(cause_o),   64'(exp_cause));
    chk({tag, ":epc"},     epc_o,          exp_epc);
    chk({tag, ":cycles"},  64'(cycles_o),  64'(cyc_exp));
    chk({tag, ":instret"}, 64'(instret_o), 64'(ins_exp));
  endtask

  // Called at posedge+1 with inputs set; checks pc_we, advances one cycle.
  task automatic step_cyc(input string tag, input logic we);
    #1;
    chk({tag, ":pc_we"}, 64'(pc_we_o), 64'(we));
    if (we) ins_exp++;
    @(posedge clk_i);
    if (live) cyc_exp++;
    #1;
  endtask

  // Asynchronous reset: outputs clear before any clock edge.
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    live = 1'b0;
    cyc_exp = '0;
    ins_exp = '0;
    exp_cause = '0;
    exp_epc = '0;
    #1;
    check_all({tag, ":async"}, ST_RST);
    chk({tag, ":async_pc_we"}, 64'(pc_we_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    exc_i = '0;
    run_i = 1'b0;
    step_i = 1'b0;
    check_all({tag, ":rst_cycle"}, ST_RST);
    step_cyc({tag, ":rst_cycle"}, 1'b0);
    live = 1'b1;
    check_all({tag, ":first_run"}, ST_RUN);
  endtask

  initial begin
    #2;
    do_reset("init");

    // free run: counters move together
    for (int i = 0; i < 4; i++) begin
      pc_i = 64'h8000_0000 + 64'(4 * i);
      step_cyc("run", 1'b1);
    end
    check_all("run4", ST_RUN);
    chk("run4_cycles_val", 64'(cycles_o), 64'd4);

    // ebreak halt, then resume with ebreak still present (skip)
    pc_i = 64'h8000_0010;
    exc_i = 6'b100000;
    step_cyc("ebreak", 1'b0);
    exp_cause = 4'd9;
    exp_epc = 64'h8000_0010;
    check_all("ebreak_halt", ST_HALT);
    step_cyc("halt_idle", 1'b0);
    check_all("halt_idle", ST_HALT);
    run_i = 1'b1;
    step_cyc("resume_req", 1'b0);
    run_i = 1'b0;
    check_all("resume_skip", ST_RUN);
    step_cyc("resume_skip", 1'b1);
    exc_i = '0;
    pc_i = 64'h8000_0014;
    check_all("no_rehalt", ST_RUN);

    // breakpoint 0 enabled; bp1 disabled at a PC that is passed
    bp_addr_i[0 +: DW]  = 64'h8000_0020;
    bp_addr_i[DW +: DW] = 64'h8000_0018;
    bp_en_i = 2'b01;
    step_cyc("bp_pre0", 1'b1);
    pc_i = 64'h8000_0018;
    step_cyc("bp1_disabled", 1'b1);
    pc_i = 64'h8000_001c;
    step_cyc("bp_pre2", 1'b1);
    pc_i = 64'h8000_0020;
    step_cyc("bp0_hit", 1'b0);
    exp_cause = 4'd10;
    exp_epc = 64'h8000_0020;
    check_all("bp0_halt", ST_HALT);

    // single step past the breakpoint
    step_i = 1'b1;
    step_cyc("step_req", 1'b0);
    step_i = 1'b0;
    check_all("step_state", ST_STEP);
    step_cyc("step_exec", 1'b1);
    pc_i = 64'h8000_0024;
    check_all("step_back_halt", ST_HALT);
    step_cyc("step_hold", 1'b0);
    check_all("step_hold", ST_HALT);

    // resume, then hit enabled bp1
    run_i = 1'b1;
    step_cyc("resume2", 1'b0);
    run_i = 1'b0;
    step_cyc("resume2_skip", 1'b1);
    bp_addr_i[DW +: DW] = 64'h8000_0028;
    bp_en_i = 2'b11;
    pc_i = 64'h8000_0028;
    step_cyc("bp1_hit", 1'b0);
    exp_epc = 64'h8000_0028;
    check_all("bp1_halt", ST_HALT);

    // bp_hit together with ebreak -> EBREAK cause
    run_i = 1'b1;
    step_cyc("resume3", 1'b0);
    run_i = 1'b0;
    pc_i = 64'h8000_002c;
    step_cyc("resume3_skip", 1'b1);
    pc_i = 64'h8000_0020;
    exc_i = 6'b100000;
    step_cyc("bp_ebreak", 1'b0);
    exc_i = '0;
    exp_cause = 4'd9;
    exp_epc = 64'h8000_0020;
    check_all("bp_ebreak_halt", ST_HALT);

    // run and step both asserted -> RUN
    bp_en_i = 2'b00;
    run_i = 1'b1;
    step_i = 1'b1;
    step_cyc("run_and_step", 1'b0);
    run_i = 1'b0;
    step_i = 1'b0;
    check_all("run_and_step", ST_RUN);
    pc_i = 64'h8000_0030;
    step_cyc("run_and_step_skip", 1'b1);

    // anomaly bit 2 -> ERROR cause 3, sticky
    pc_i = 64'h8000_0034;
    exc_i = 6'b000100;
    step_cyc("anomaly2", 1'b0);
    exc_i = '0;
    exp_cause = 4'd3;
    exp_epc = 64'h8000_0034;
    check_all("anomaly2_err", ST_ERROR);
    run_i = 1'b1;
    step_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_cyc("err_sticky", 1'b0);
      chk("err_sticky_state", 64'(state_o), 64'(ST_ERROR));
    end
    check_all("err_after10", ST_ERROR);
    run_i = 1'b0;
    step_i = 1'b0;

    // reset mid-ERROR
    do_reset("mid_err");

    // ecall halt, resume with ecall masked by skip
    pc_i = 64'h8000_0048;
    exc_i = 6'b010000;
    step_cyc("ecall", 1'b0);
    exp_cause = 4'd8;
    exp_epc = 64'h8000_0048;
    check_all("ecall_halt", ST_HALT);
    run_i = 1'b1;
    step_cyc("resume4", 1'b0);
    run_i = 1'b0;
    step_cyc("ecall_skip", 1'b1);
    exc_i = '0;
    pc_i = 64'h8000_004c;
    step_cyc("ecall_pass", 1'b1);
    check_all("ecall_pass", ST_RUN);

    // ebreak halt, then anomaly in the skip cycle is not masked
    pc_i = 64'h8000_0050;
    exc_i = 6'b100000;
    step_cyc("ebreak2", 1'b0);
    exp_cause = 4'd9;
    exp_epc = 64'h8000_0050;
    check_all("ebreak2_halt", ST_HALT);
    run_i = 1'b1;
    step_cyc("resume5", 1'b0);
    run_i = 1'b0;
    exc_i = 6'b100001;
    step_cyc("skip_anomaly", 1'b0);
    exc_i = '0;
    exp_cause = 4'd1;
    check_all("skip_anomaly_err", ST_ERROR);

    // anomaly bit 0 plus ebreak directly in RUN -> ERROR cause 1
    do_reset("combo");
    pc_i = 64'h8000_0060;
    exc_i = 6'b100001;
    step_cyc("combo", 1'b0);
    exc_i = '0;
    exp_cause = 4'd1;
    exp_epc = 64'h8000_0060;
    check_all("combo_err", ST_ERROR);

    // counter wrap at 4 bits
    do_reset("wrap");
    for (int i = 0; i < 20; i++) begin
      pc_i = 64'h8000_1000 + 64'(4 * i);
      step_cyc("wrap", 1'b1);
      check_all("wrap", ST_RUN);
    end
    chk("wrap_cycles_val", 64'(cycles_o), 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard time limit
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
